i2c_access_sched: RTL



---
 rtl/i2c_access_sched.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_access_sched.sv
// Arbiter/sequencer sharing one I2C master between host register accesses and a
// periodic 11-byte sensor poll, with a per-transaction watchdog.
module i2c_access_sched #(
  parameter int unsigned POLL_PERIOD = 500000,
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter logic [2:0]  CLK_RATE    = 3'd6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_host_req,
  input  logic        i_host_rw,
  input  logic        i_host_burst,
  input  logic [6:0]  i_host_dev,
  input  logic [7:0]  i_host_reg,
  input  logic [7:0]  i_host_wdata,
  output logic        o_host_ack,
  output logic        o_host_done,
  output logic        o_host_err,
  input  logic        i_poll_en,
  input  logic [6:0]  i_poll_dev,
  input  logic [7:0]  i_poll_reg,
  output logic [87:0] o_poll_data,
  output logic        o_poll_valid,
  output logic [7:0]  o_poll_overrun,
  output logic [31:0] o_ctrl,
  output logic [6:0]  o_dev_addr,
  output logic [7:0]  o_reg_addr,
  output logic [7:0]  o_w_data,
  input  logic [31:0] i_status,
  input  logic [87:0] i_rd_data,
  output logic        o_busy
);

  localparam int unsigned PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_ISSUE, S_BUSY, S_DRAIN, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     sync1_q, sync2_q;
  logic           fin_prev_q;
  logic [PW-1:0]  ptmr_q, ptmr_d;
  logic           pend_q, pend_d;
  logic [7:0]     ovr_q, ovr_d;
  logic           last_poll_q, last_poll_d;
  logic           gnt_poll_q, gnt_poll_d;
  logic           err_q, err_d;
  logic [WW-1:0]  wd_q, wd_d;
  logic           en_q, en_d;
  logic           rw_q, rw_d;
  logic [1:0]     mode_q, mode_d;
  logic [6:0]     dev_q, dev_d;
  logic [7:0]     reg_q, reg_d;
  logic [7:0]     wdat_q, wdat_d;
  logic [87:0]    pdata_q, pdata_d;

  logic rdy, fin_evt, tick, wd_to, poll_wins;
  logic unused_status;

  assign unused_status = ^i_status[31:2];
  assign rdy     = sync2_q[0];
  assign fin_evt = sync2_q[1] & ~fin_prev_q;
  assign wd_to   = (wd_q == WW'(TIMEOUT_CYC - 1));
  // Round-robin: a pending poll loses only to a host request when the poll went last.
  assign poll_wins = pend_q && (!i_host_req || !last_poll_q);

  always_comb begin
    state_d     = state_q;
    ptmr_d      = ptmr_q;
    pend_d      = pend_q;
    ovr_d       = ovr_q;
    last_poll_d = last_poll_q;
    gnt_poll_d  = gnt_poll_q;
    err_d       = err_q;
    wd_d        = wd_q;
    en_d        = en_q;
    rw_d        = rw_q;
    mode_d      = mode_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdat_d      = wdat_q;
    pdata_d     = pdata_q;
    tick        = 1'b0;

    if (!i_poll_en) begin
      ptmr_d = '0;
    end else if (ptmr_q == PW'(POLL_PERIOD - 1)) begin
      ptmr_d = '0;
      tick   = 1'b1;
    end else begin
      ptmr_d = ptmr_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q || i_host_req) begin
          state_d    = S_GRANT;
          gnt_poll_d = poll_wins;
          if (poll_wins) begin
            pend_d = 1'b0;
            dev_d  = i_poll_dev;
            reg_d  = i_poll_reg;
            wdat_d = '0;
            rw_d   = 1'b1;
            mode_d = 2'b01;
          end else begin
            dev_d  = i_host_dev;
            reg_d  = i_host_reg;
            wdat_d = i_host_wdata;
            rw_d   = i_host_rw;
            mode_d = {1'b0, i_host_burst};
          end
        end
      end
      S_GRANT: begin
        last_poll_d = gnt_poll_q;
        en_d        = 1'b1;
        wd_d        = '0;
        err_d       = 1'b0;
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        wd_d = wd_q + 1'b1;
        if (wd_to) begin
          en_d = 1'b0; err_d = 1'b1; state_d = S_DONE;
        end else if (!rdy) begin
          en_d = 1'b0; state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        wd_d = wd_q + 1'b1;
        if (fin_evt) begin
          state_d = S_DRAIN;
        end else if (wd_to) begin
          err_d = 1'b1; state_d = S_DONE;
        end
      end
      S_DRAIN: begin
        wd_d = wd_q + 1'b1;
        if (rdy) begin
          state_d = S_DONE;
          if (gnt_poll_q) pdata_d = i_rd_data;
        end else if (wd_to) begin
          err_d = 1'b1; state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tick) begin
      if (pend_q) begin
        if (ovr_q != 8'hFF) ovr_d = ovr_q + 1'b1;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      fin_prev_q <= 1'b0;
    end else begin
      sync1_q    <= i_status[1:0];
      sync2_q    <= sync1_q;
      fin_prev_q <= sync2_q[1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      ptmr_q      <= '0;
      pend_q      <= 1'b0;
      ovr_q       <= '0;
      last_poll_q <= 1'b0;
      gnt_poll_q  <= 1'b0;
      err_q       <= 1'b0;
      wd_q        <= '0;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      mode_q      <= '0;
      dev_q       <= '0;
      reg_q       <= '0;
      wdat_q      <= '0;
      pdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptmr_q      <= ptmr_d;
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
      last_poll_q <= last_poll_d;
      gnt_poll_q  <= gnt_poll_d;
      err_q       <= err_d;
      wd_q        <= wd_d;
      en_q        <= en_d;
      rw_q        <= rw_d;
      mode_q      <= mode_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdat_q      <= wdat_d;
      pdata_q     <= pdata_d;
    end
  end

  assign o_host_ack     = (state_q == S_GRANT) && !gnt_poll_q;
  assign o_host_done    = (state_q == S_DONE) && !gnt_poll_q;
  assign o_host_err     = o_host_done && err_q;
  assign o_poll_valid   = (state_q == S_DONE) && gnt_poll_q && !err_q;
  assign o_poll_data    = pdata_q;
  assign o_poll_overrun = ovr_q;
  assign o_ctrl         = {25'd0, CLK_RATE, mode_q, rw_q, en_q};
  assign o_dev_addr     = dev_q;
  assign o_reg_addr     = reg_q;
  assign o_w_data       = wdat_q;
  assign o_busy         = (state_q != S_IDLE);

endmodule
